plot_fb_writer: RTL and testbench

Sink end of the pixel plot interface (iX/iY/iColour/iPlot) that the rasterisers (draw_triangle, line/rect drawers) drive. Buffers plot requests in a small FIFO, clips them to the screen, converts (x,y) to a linear framebuffer address and issues ready/valid writes to a framebuffer RAM port. Also performs a full-screen clear sweep on request. Sits between the drawing engines and the framebuffer memory feeding the VGA scan-out.

---
 rtl/plot_fb_writer_pkg.sv | 37 +++
 rtl/plot_fb_writer_if.sv | 13 +
 rtl/plot_fb_writer_fifo.sv | 45 ++++
 rtl/plot_fb_writer.sv | 210 +++++++++++++++++++++
 tb/tb_plot_fb_writer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/plot_fb_writer_pkg.sv
// Shared definitions for the plot framebuffer writer: screen geometry, pixel record layout,
// writer FSM states and the shift-add framebuffer address helper.
package plot_pkg;

  localparam int unsigned SCREEN_W  = 320;
  localparam int unsigned SCREEN_H  = 240;
  localparam int unsigned FB_ADDR_W = 17;
  localparam int unsigned COLOUR_W  = 3;

  localparam int unsigned PIX_X_W = 9;
  localparam int unsigned PIX_Y_W = 8;

  typedef struct packed {
    logic [PIX_X_W-1:0]  x;
    logic [PIX_Y_W-1:0]  y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrain = 2'd1,
    StClear = 2'd2
  } state_e;

  // y*width + x built from shifted copies of y; width is a constant so only adders remain.
  function automatic logic [31:0] fb_addr(input logic [PIX_X_W-1:0] x,
                                          input logic [PIX_Y_W-1:0] y,
                                          input int unsigned width);
    logic [31:0] acc;
    acc = {23'd0, x};
    for (int i = 0; i < 32; i++) begin
      if (width[i]) acc = acc + ({24'd0, y} << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/plot_fb_writer_if.sv
// Framebuffer RAM write port: registered address/data/valid from the writer, ready from memory.
interface plot_fb_writer_if #(
  parameter int unsigned ADDR_W   = plot_pkg::FB_ADDR_W,
  parameter int unsigned COLOUR_W = plot_pkg::COLOUR_W
);
  logic [ADDR_W-1:0]   mem_addr;
  logic [COLOUR_W-1:0] mem_data;
  logic                mem_we;
  logic                mem_ready;

  modport master (output mem_addr, output mem_data, output mem_we, input mem_ready);
  modport slave  (input mem_addr, input mem_data, input mem_we, output mem_ready);
endinterface

// File: rtl/plot_fb_writer_fifo.sv
// Synchronous FIFO for plot requests; pointer-derived full/empty, push ignored when full,
// pop ignored when empty.
module plot_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W:0]   r_wr_ptr;
  logic [PTR_W:0]   r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_data  = r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= i_data;
  end

endmodule

// File: rtl/plot_fb_writer.sv
// Plot sink: queues pixels, clips, maps (x,y) to a linear address and writes the framebuffer;
// also sweeps a full-screen clear. Optional clip counter under `PLOT_FB_CLIP_STATS_EN.
module plot_fb_writer import plot_pkg::*; #(
  parameter int unsigned WIDTH      = SCREEN_W,
  parameter int unsigned HEIGHT     = SCREEN_H,
  parameter int unsigned COLOUR_W   = plot_pkg::COLOUR_W,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = FB_ADDR_W
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [8:0]          iX,
  input  logic [7:0]          iY,
  input  logic [COLOUR_W-1:0] iColour,
  input  logic                iPlot,
  output logic                oReady,
  input  logic                iClear,
  input  logic [COLOUR_W-1:0] iClearColour,
  output logic                oBusy,
  output logic                oOverflow,
`ifdef PLOT_FB_CLIP_STATS_EN
  output logic [15:0]         oClipCount,
`endif
  plot_fb_writer_if.master    fb
);
  localparam int unsigned       PIX_W     = PIX_X_W + PIX_Y_W + COLOUR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

  state_e r_state;
  state_e w_state_d;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [PIX_W-1:0]    w_pop_data;
  logic [PIX_X_W-1:0]  w_pop_x;
  logic [PIX_Y_W-1:0]  w_pop_y;
  logic [COLOUR_W-1:0] w_pop_c;
  logic                w_clip;
  logic [ADDR_W-1:0]   w_addr;

  // Pop/address stage between the FIFO and the output register.
  logic                r_p_valid;
  logic [ADDR_W-1:0]   r_p_addr;
  logic [COLOUR_W-1:0] r_p_data;

  logic                r_pend;
  logic [COLOUR_W-1:0] r_clr_colour;
  logic [ADDR_W-1:0]   r_clr_addr;
  logic                r_clr_issued;
  logic                w_clear_enter;
  logic                w_clr_load;

  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [COLOUR_W-1:0] r_mem_data;
  logic                w_mem_we_d;
  logic [ADDR_W-1:0]   w_mem_addr_d;
  logic [COLOUR_W-1:0] w_mem_data_d;
  logic                w_out_free;
  logic                w_stage_free;

  logic                r_overflow;

  plot_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_data  ({iX, iY, iColour}),
    .i_pop   (w_pop),
    .o_data  (w_pop_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_pop_x = w_pop_data[PIX_W-1 -: PIX_X_W];
  assign w_pop_y = w_pop_data[COLOUR_W +: PIX_Y_W];
  assign w_pop_c = w_pop_data[COLOUR_W-1:0];
  assign w_clip  = (32'(w_pop_x) >= WIDTH) || (32'(w_pop_y) >= HEIGHT);
  assign w_addr  = ADDR_W'(fb_addr(w_pop_x, w_pop_y, WIDTH));

  assign oReady       = !w_full;
  assign w_push       = iPlot && !w_full;
  assign w_out_free   = !r_mem_we || fb.mem_ready;
  assign w_stage_free = !r_p_valid || (w_out_free && (r_state != StClear));
  assign w_pop        = !w_empty && w_stage_free && (r_state != StClear);

  // Queued plots always win over a pending clear, so earlier pixels land first.
  assign w_clear_enter = (r_state == StIdle) && w_empty && r_pend;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (!w_empty)    w_state_d = StDrain;
        else if (r_pend) w_state_d = StClear;
      end
      StDrain: begin
        if (w_empty && !r_p_valid && w_out_free) w_state_d = StIdle;
      end
      StClear: begin
        if (r_clr_issued && r_mem_we && fb.mem_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_mem_we_d   = r_mem_we;
    w_mem_addr_d = r_mem_addr;
    w_mem_data_d = r_mem_data;
    w_clr_load   = 1'b0;
    if (w_out_free) begin
      w_mem_we_d = 1'b0;
      if (r_state == StClear) begin
        if (!r_clr_issued) begin
          w_mem_we_d   = 1'b1;
          w_mem_addr_d = r_clr_addr;
          w_mem_data_d = r_clr_colour;
          w_clr_load   = 1'b1;
        end
      end else if (r_p_valid) begin
        w_mem_we_d   = 1'b1;
        w_mem_addr_d = r_p_addr;
        w_mem_data_d = r_p_data;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= StIdle;
      r_mem_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_mem_we   <= w_mem_we_d;
      r_mem_addr <= w_mem_addr_d;
      r_mem_data <= w_mem_data_d;
      if (iPlot && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_p_valid <= 1'b0;
      r_p_addr  <= '0;
      r_p_data  <= '0;
    end else if (w_pop) begin
      r_p_valid <= !w_clip;
      r_p_addr  <= w_addr;
      r_p_data  <= w_pop_c;
    end else if (w_out_free && (r_state != StClear)) begin
      r_p_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_pend       <= 1'b0;
      r_clr_colour <= '0;
      r_clr_addr   <= '0;
      r_clr_issued <= 1'b0;
    end else begin
      if (w_clear_enter) begin
        r_pend       <= 1'b0;
        r_clr_addr   <= '0;
        r_clr_issued <= 1'b0;
      end else begin
        if (iClear && !r_pend && (r_state != StClear)) begin
          r_pend       <= 1'b1;
          r_clr_colour <= iClearColour;
        end
        if (w_clr_load) begin
          if (r_clr_addr == LAST_ADDR) r_clr_issued <= 1'b1;
          else                         r_clr_addr   <= r_clr_addr + 1'b1;
        end
      end
    end
  end

`ifdef PLOT_FB_CLIP_STATS_EN
  logic [15:0] r_clip_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_clip_cnt <= '0;
    end else if (w_clear_enter) begin
      r_clip_cnt <= '0;
    end else if (w_pop && w_clip && (r_clip_cnt != 16'hFFFF)) begin
      r_clip_cnt <= r_clip_cnt + 16'd1;
    end
  end

  assign oClipCount = r_clip_cnt;
`endif

  assign fb.mem_we   = r_mem_we;
  assign fb.mem_addr = r_mem_addr;
  assign fb.mem_data = r_mem_data;
  assign oOverflow   = r_overflow;
  assign oBusy       = !w_empty || r_pend || (r_state != StIdle) || r_mem_we || r_p_valid;

endmodule

// File: tb/tb_plot_fb_writer.sv
// Bench for plot_fb_writer: a queue of expected framebuffer writes (pixels and clear sweeps)
// checked against every accepted write, plus literal checks on latency, capacity and reset.
`timescale 1ns/1ps
module tb_plot_fb_writer;
  localparam int unsigned W  = 320;
  localparam int unsigned H  = 240;
  localparam int unsigned FB = W * H;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [8:0] iX = '0;
  logic [7:0] iY = '0;
  logic [2:0] iColour = '0;
  logic       iPlot = 1'b0;
  logic       oReady;
  logic       iClear = 1'b0;
  logic [2:0] iClearColour = '0;
  logic       oBusy;
  logic       oOverflow;
`ifdef PLOT_FB_CLIP_STATS_EN
  logic [15:0] clip_count;
`endif

  plot_fb_writer_if fb_bus ();

  always #5 clock = ~clock;

  plot_fb_writer dut (
    .clock        (clock),
    .resetn       (resetn),
    .iX           (iX),
    .iY           (iY),
    .iColour      (iColour),
    .iPlot        (iPlot),
    .oReady       (oReady),
    .iClear       (iClear),
    .iClearColour (iClearColour),
    .oBusy        (oBusy),
    .oOverflow    (oOverflow),
`ifdef PLOT_FB_CLIP_STATS_EN
    .oClipCount   (clip_count),
`endif
    .fb           (fb_bus)
  );

  typedef struct {
    bit          is_clr;
    int unsigned addr;
    logic [2:0]  data;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned clr_idx = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int unsigned n_writes = 0;
  int unsigned last_addr = 0;
  logic [2:0]  last_data = '0;
  bit          prev_stall = 1'b0;
  logic [16:0] prev_addr = '0;
  logic [2:0]  prev_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected write stream: pixels in acceptance order, a clear expands to addresses 0..FB-1.
  always @(negedge clock) begin
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_we", 32'(fb_bus.mem_we), 32'd1);
        check("stall_addr", 32'(fb_bus.mem_addr), 32'(prev_addr));
        check("stall_data", 32'(fb_bus.mem_data), 32'(prev_data));
      end
      if (fb_bus.mem_we && fb_bus.mem_ready) begin
        n_writes++;
        last_addr = 32'(fb_bus.mem_addr);
        last_data = fb_bus.mem_data;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_write: got addr %0d data %0d expected no write",
                   fb_bus.mem_addr, fb_bus.mem_data);
        end else begin
          int unsigned ea;
          logic [2:0]  ed;
          ed = exp_q[0].data;
          if (exp_q[0].is_clr) begin
            ea = clr_idx;
            clr_idx++;
            if (clr_idx == FB) begin
              clr_idx = 0;
              void'(exp_q.pop_front());
            end
          end else begin
            ea = exp_q[0].addr;
            void'(exp_q.pop_front());
          end
          check("wr_addr", 32'(fb_bus.mem_addr), ea);
          check("wr_data", 32'(fb_bus.mem_data), 32'(ed));
        end
      end
      prev_stall = fb_bus.mem_we && !fb_bus.mem_ready;
      prev_addr  = fb_bus.mem_addr;
      prev_data  = fb_bus.mem_data;
    end
  end

  function automatic bit clear_in_model();
    foreach (exp_q[i]) if (exp_q[i].is_clr) return 1'b1;
    return 1'b0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Called at posedge+1; the request is presented for one edge and returns at posedge+1.
  task automatic push(input int x, input int y, input int c, output bit acc);
    exp_t e;
    iX = 9'(x);
    iY = 8'(y);
    iColour = 3'(c);
    iPlot = 1'b1;
    @(negedge clock);
    acc = oReady;
    if (acc && (x < int'(W)) && (y < int'(H))) begin
      e.is_clr = 1'b0;
      e.addr   = 32'(y) * W + 32'(x);
      e.data   = 3'(c);
      exp_q.push_back(e);
    end
    tick();
    iPlot = 1'b0;
  endtask

  task automatic clear_req(input logic [2:0] c);
    exp_t e;
    iClear = 1'b1;
    iClearColour = c;
    if (!clear_in_model()) begin
      e.is_clr = 1'b1;
      e.addr   = 0;
      e.data   = c;
      exp_q.push_back(e);
    end
    tick();
    iClear = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((oBusy !== 1'b0) && (n < budget)) begin
      tick();
      n++;
    end
    check(name, 32'(oBusy), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    int          acc_cnt;
    int unsigned n0;
    int          budget;

    fb_bus.mem_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("rst_we", 32'(fb_bus.mem_we), 32'd0);
    check("rst_addr", 32'(fb_bus.mem_addr), 32'd0);
    check("rst_data", 32'(fb_bus.mem_data), 32'd0);
    check("rst_ready", 32'(oReady), 32'd1);
    check("rst_busy", 32'(oBusy), 32'd0);
    check("rst_ovf", 32'(oOverflow), 32'd0);
    resetn = 1'b1;
    tick();

    // Single plot latency: accepted at edge N, mem_we seen after edge N+2.
    n0 = n_writes;
    push(125, 34, 7, acc);
    check("t1_acc", 32'(acc), 32'd1);
    @(negedge clock);
    check("lat_we_n0", 32'(fb_bus.mem_we), 32'd0);
    @(negedge clock);
    check("lat_we_n1", 32'(fb_bus.mem_we), 32'd0);
    @(negedge clock);
    check("lat_we_n2", 32'(fb_bus.mem_we), 32'd1);
    check("lat_addr", 32'(fb_bus.mem_addr), 32'd11005);
    check("lat_data", 32'(fb_bus.mem_data), 32'd7);
    tick();
    wait_idle("t1_idle", 20);
    check("t1_count", n_writes - n0, 32'd1);
    check("t1_last_addr", last_addr, 32'd11005);

    // Back-pressure: 16 FIFO entries + pop stage + output register hold 18 pixels.
    fb_bus.mem_ready = 1'b0;
    n0 = n_writes;
    acc_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      push(i * 7, i + 3, i % 8, acc);
      if (i == 0) check("ovf_clear_early", 32'(oOverflow), 32'd0);
      acc_cnt += int'(acc);
    end
    check("ovf_accepted", 32'(acc_cnt), 32'd18);
    check("ovf_ready_low", 32'(oReady), 32'd0);
    check("ovf_sticky", 32'(oOverflow), 32'd1);
    budget = 0;
    while ((oBusy !== 1'b0) && (budget < 400)) begin
      fb_bus.mem_ready = 1'($urandom_range(0, 1));
      tick();
      budget++;
    end
    fb_bus.mem_ready = 1'b1;
    wait_idle("t2_idle", 50);
    check("t2_count", n_writes - n0, 32'd18);
    check("t2_queue_empty", 32'(exp_q.size()), 32'd0);
    check("t2_ovf_still", 32'(oOverflow), 32'd1);

    // Clipping at the screen edges.
    n0 = n_writes;
    push(319, 239, 5, acc);
    push(320, 0, 1, acc);
    push(0, 240, 2, acc);
    wait_idle("t3_idle", 30);
    check("clip_count_wr", n_writes - n0, 32'd1);
    check("clip_last_addr", last_addr, 32'd76799);
    check("clip_last_data", 32'(last_data), 32'd5);
`ifdef PLOT_FB_CLIP_STATS_EN
    check("clip_stat", 32'(clip_count), 32'd2);
`endif

    // Full clear, a plot queued mid-sweep, and a second clear request that must be ignored.
    n0 = n_writes;
    clear_req(3'b010);
    budget = 0;
    while ((clr_idx < 500) && (budget < 2000)) begin
      tick();
      budget++;
    end
    check("clr_progress", 32'(clr_idx >= 500), 32'd1);
    push(5, 5, 6, acc);
    check("clr_plot_acc", 32'(acc), 32'd1);
    clear_req(3'b101);
    check("clr_busy_mid", 32'(oBusy), 32'd1);
    wait_idle("t4_idle", 80000);
    check("clr_count", n_writes - n0, 32'd76801);
    check("clr_last_addr", last_addr, 32'd1605);
    check("clr_last_data", 32'(last_data), 32'd6);
    check("clr_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef PLOT_FB_CLIP_STATS_EN
    check("clip_stat_cleared", 32'(clip_count), 32'd0);
`endif

    // Stalled clear sweep, then asynchronous reset near address 1000.
    clear_req(3'b011);
    budget = 0;
    while ((clr_idx < 1000) && (budget < 5000)) begin
      fb_bus.mem_ready = 1'($urandom_range(0, 1));
      tick();
      budget++;
    end
    check("rnd_progress", 32'(clr_idx >= 1000), 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_we", 32'(fb_bus.mem_we), 32'd0);
    check("arst_busy", 32'(oBusy), 32'd0);
    check("arst_ovf", 32'(oOverflow), 32'd0);
    check("arst_ready", 32'(oReady), 32'd1);
    exp_q.delete();
    clr_idx = 0;
    tick();
    tick();
    resetn = 1'b1;
    fb_bus.mem_ready = 1'b1;
    n0 = n_writes;
    repeat (50) tick();
    check("post_rst_writes", n_writes - n0, 32'd0);
    check("post_rst_busy", 32'(oBusy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
